// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared types and timing constants for the button conditioner
//
// Purpose: hold-state encoding, 50 MHz default timing constants and a
//          millisecond-to-cycle conversion used for parameter defaults.
// Ports:   none (package).

package btn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } hold_state_e;

  localparam int CLK_HZ = 50_000_000;

  // Cycles of CLOCK_50 in the given number of milliseconds.
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEF_DEBOUNCE = ms_to_cycles(20);
  localparam int DEF_LONG     = ms_to_cycles(1000);
  localparam int DEF_REPEAT   = ms_to_cycles(200);

endpackage

// File: rtl/btn_debounce_array_if.sv
// rtl/btn_debounce_array_if.sv - button bus between board pins, conditioner and user logic
//
// Purpose: bundles the raw button inputs, repeat enables and all conditioned
//          outputs of a btn_debounce_array.
// Ports (signals, N_CH bits each):
//   btn_i     raw asynchronous button pins
//   repeat_en per-channel auto-repeat enable
//   level_o   debounced pressed level (1 = pressed)
//   press_o   one-cycle press pulse
//   release_o one-cycle release pulse
//   long_o    one-cycle long-press pulse
//   repeat_o  one-cycle auto-repeat pulse
// Modports: master drives buttons/enables, slave is the conditioner.

interface btn_debounce_array_if #(
  parameter int N_CH = 4
) ();

  logic [N_CH-1:0] btn_i;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] long_o;
  logic [N_CH-1:0] repeat_o;

  modport master (
    output btn_i,
    output repeat_en,
    input  level_o,
    input  press_o,
    input  release_o,
    input  long_o,
    input  repeat_o
  );

  modport slave (
    input  btn_i,
    input  repeat_en,
    output level_o,
    output press_o,
    output release_o,
    output long_o,
    output repeat_o
  );

endinterface

// File: rtl/btn_debounce_channel.sv
// rtl/btn_debounce_channel.sv - synchroniser, debounce filter and hold FSM for one button
//
// Purpose: conditions a single raw button into a clean level and one-cycle
//          press / release / long-press / auto-repeat pulses.
// Ports:
//   CLOCK_50  in   clock, rising edge
//   reset     in   synchronous active-high reset
//   btn_raw   in   raw asynchronous button pin
//   repeat_en in   auto-repeat enable, sampled every cycle
//   level_o   out  debounced level, 1 = pressed
//   press_o   out  one-cycle pulse on debounced press
//   release_o out  one-cycle pulse on debounced release
//   long_o    out  one-cycle pulse after LONG_CYCLES held
//   repeat_o  out  one-cycle pulses every REPEAT_CYCLES past long-press

module btn_debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int LONG_CYCLES     = DEF_LONG,
  parameter int REPEAT_CYCLES   = DEF_REPEAT
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic              pressed_raw;
  logic              sync_1;
  logic              sync_2;
  logic              db_fire;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  hold_state_e       state;

  // Normalise so the rest of the channel always sees 1 = pressed.
  assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // The filter commits on this edge: sync has disagreed with level for a full window.
  assign db_fire = (sync_2 != level_o) && (db_cnt == DB_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      level_o   <= 1'b0;
      db_cnt    <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
    end else begin
      sync_1    <= pressed_raw;
      sync_2    <= sync_1;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;

      // Any cycle of agreement restarts the window, so bounce never accumulates.
      if (sync_2 == level_o) begin
        db_cnt <= '0;
      end else if (db_fire) begin
        level_o   <= sync_2;
        db_cnt    <= '0;
        press_o   <= sync_2;
        release_o <= ~sync_2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // Release wins over any long/repeat boundary landing on the same edge.
      if (db_fire && !sync_2) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (db_fire && sync_2) begin
              state    <= ST_HELD;
              hold_cnt <= '0;
            end
          end
          ST_HELD: begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_LONG;
              long_o   <= 1'b1;
              repeat_o <= repeat_en;
              rep_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_LONG: begin
            // rep_cnt free-runs so toggling repeat_en never shifts the phase.
            if (rep_cnt == REP_LAST) begin
              rep_cnt  <= '0;
              repeat_o <= repeat_en;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_debounce_array.sv
// rtl/btn_debounce_array.sv - multi-channel push-button conditioner
//
// Purpose: N_CH independent button channels, each synchronised, debounced and
//          decoded into level, press, release, long-press and repeat outputs.
// Ports:
//   CLOCK_50  in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   bus       slave side of btn_debounce_array_if (btn_i, repeat_en in;
//             level_o, press_o, release_o, long_o, repeat_o out)

module btn_debounce_array
  import btn_debounce_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int LONG_CYCLES     = DEF_LONG,
  parameter int REPEAT_CYCLES   = DEF_REPEAT
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  btn_debounce_array_if.slave bus
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("btn_debounce_array: N_CH must be 1..32");
  end
  if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_active_low
    $error("btn_debounce_array: ACTIVE_LOW must be 0 or 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce_array: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("btn_debounce_array: LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("btn_debounce_array: REPEAT_CYCLES must be >= 2");
  end

  logic [N_CH-1:0] level_v;
  logic [N_CH-1:0] press_v;
  logic [N_CH-1:0] release_v;
  logic [N_CH-1:0] long_v;
  logic [N_CH-1:0] repeat_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .btn_raw   (bus.btn_i[i]),
      .repeat_en (bus.repeat_en[i]),
      .level_o   (level_v[i]),
      .press_o   (press_v[i]),
      .release_o (release_v[i]),
      .long_o    (long_v[i]),
      .repeat_o  (repeat_v[i])
    );
  end

  assign bus.level_o   = level_v;
  assign bus.press_o   = press_v;
  assign bus.release_o = release_v;
  assign bus.long_o    = long_v;
  assign bus.repeat_o  = repeat_v;

endmodule

// File: tb/tb_btn_debounce_array.sv
// tb/tb_btn_debounce_array.sv - scoreboard bench for btn_debounce_array

module tb_btn_debounce_array;

  localparam int N_CH = 2;

  typedef struct {
    int          cyc;
    string       kind;
    logic [1:0]  val;
  } ev_t;

  logic CLOCK_50;
  logic reset;
  int   cyc;
  int   checks;
  int   passed;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  btn_debounce_array_if #(.N_CH(N_CH)) bus ();

  btn_debounce_array #(
    .N_CH            (N_CH),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (32),
    .REPEAT_CYCLES   (8)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Every nonzero pulse output becomes an observed event tagged with its cycle.
  always @(negedge CLOCK_50) begin
    if (bus.press_o   != 2'b00) obs_q.push_back('{cyc: cyc, kind: "press",   val: bus.press_o});
    if (bus.release_o != 2'b00) obs_q.push_back('{cyc: cyc, kind: "release", val: bus.release_o});
    if (bus.long_o    != 2'b00) obs_q.push_back('{cyc: cyc, kind: "long",    val: bus.long_o});
    if (bus.repeat_o  != 2'b00) obs_q.push_back('{cyc: cyc, kind: "repeat",  val: bus.repeat_o});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  function automatic void expect_ev(input int c, input string k, input logic [1:0] v);
    exp_q.push_back('{cyc: c, kind: k, val: v});
  endfunction

  task automatic test_reset();
    checks++; if (bus.level_o !== 2'b00) $display("FAIL reset_level: got %b want 00", bus.level_o); else passed++;
    checks++; if (bus.press_o !== 2'b00) $display("FAIL reset_press: got %b want 00", bus.press_o); else passed++;
    checks++; if (bus.release_o !== 2'b00) $display("FAIL reset_release: got %b want 00", bus.release_o); else passed++;
    checks++; if (bus.long_o !== 2'b00) $display("FAIL reset_long: got %b want 00", bus.long_o); else passed++;
    checks++; if (bus.repeat_o !== 2'b00) $display("FAIL reset_repeat: got %b want 00", bus.repeat_o); else passed++;
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_clean_press();
    int  t;
    ev_t e, o;
    bus.btn_i[0] = 1'b0;
    t = cyc;
    expect_ev(t + 10, "press", 2'b01);
    expect_ev(t + 22, "release", 2'b01);
    tick(9);
    checks++; if (bus.level_o !== 2'b00) $display("FAIL clean_level_early: got %b want 00", bus.level_o); else passed++;
    tick(3);
    checks++; if (bus.level_o !== 2'b01) $display("FAIL clean_level_pressed: got %b want 01", bus.level_o); else passed++;
    bus.btn_i[0] = 1'b1;
    tick(12);
    checks++; if (bus.level_o !== 2'b00) $display("FAIL clean_level_released: got %b want 00", bus.level_o); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL clean_event: missing %s@%0d=%b", e.kind, e.cyc, e.val);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind != e.kind || o.val !== e.val)
          $display("FAIL clean_event: got %s@%0d=%b want %s@%0d=%b", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        else passed++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL clean_extra: got %s@%0d=%b want none", obs_q[0].kind, obs_q[0].cyc, obs_q[0].val);
      obs_q.delete();
    end else passed++;
  endtask

  task automatic test_bounce();
    int  t;
    ev_t e, o;
    bus.btn_i[0] = 1'b0; tick(5);
    bus.btn_i[0] = 1'b1; tick(2);
    bus.btn_i[0] = 1'b0; tick(5);
    bus.btn_i[0] = 1'b1; tick(12);
    checks++; if (bus.level_o !== 2'b00) $display("FAIL bounce_level: got %b want 00", bus.level_o); else passed++;
    bus.btn_i[0] = 1'b0;
    t = cyc;
    expect_ev(t + 10, "press", 2'b01);
    expect_ev(t + 22, "release", 2'b01);
    tick(12);
    checks++; if (bus.level_o !== 2'b01) $display("FAIL bounce_level_stable: got %b want 01", bus.level_o); else passed++;
    bus.btn_i[0] = 1'b1;
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL bounce_event: missing %s@%0d=%b", e.kind, e.cyc, e.val);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind != e.kind || o.val !== e.val)
          $display("FAIL bounce_event: got %s@%0d=%b want %s@%0d=%b", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        else passed++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL bounce_extra: got %s@%0d=%b want none", obs_q[0].kind, obs_q[0].cyc, obs_q[0].val);
      obs_q.delete();
    end else passed++;
  endtask

  task automatic test_long_repeat();
    int  p;
    ev_t e, o;
    bus.repeat_en = 2'b01;
    bus.btn_i[0] = 1'b0;
    p = cyc + 10;
    expect_ev(p,      "press",   2'b01);
    expect_ev(p + 32, "long",    2'b01);
    expect_ev(p + 32, "repeat",  2'b01);
    expect_ev(p + 40, "repeat",  2'b01);
    expect_ev(p + 48, "repeat",  2'b01);
    expect_ev(p + 56, "repeat",  2'b01);
    expect_ev(p + 64, "release", 2'b01);
    tick(64);
    bus.btn_i[0] = 1'b1;
    tick(24);
    bus.repeat_en = 2'b00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL long_event: missing %s@%0d=%b", e.kind, e.cyc, e.val);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind != e.kind || o.val !== e.val)
          $display("FAIL long_event: got %s@%0d=%b want %s@%0d=%b", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        else passed++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL long_extra: got %s@%0d=%b want none", obs_q[0].kind, obs_q[0].cyc, obs_q[0].val);
      obs_q.delete();
    end else passed++;
  endtask

  task automatic test_repeat_gating();
    int  p;
    ev_t e, o;
    bus.repeat_en = 2'b00;
    bus.btn_i[0] = 1'b0;
    p = cyc + 10;
    expect_ev(p,      "press",   2'b01);
    expect_ev(p + 32, "long",    2'b01);
    expect_ev(p + 48, "repeat",  2'b01);
    expect_ev(p + 56, "repeat",  2'b01);
    expect_ev(p + 60, "release", 2'b01);
    tick(54);
    bus.repeat_en = 2'b01;
    tick(6);
    bus.btn_i[0] = 1'b1;
    tick(14);
    bus.repeat_en = 2'b00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL gating_event: missing %s@%0d=%b", e.kind, e.cyc, e.val);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind != e.kind || o.val !== e.val)
          $display("FAIL gating_event: got %s@%0d=%b want %s@%0d=%b", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        else passed++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL gating_extra: got %s@%0d=%b want none", obs_q[0].kind, obs_q[0].cyc, obs_q[0].val);
      obs_q.delete();
    end else passed++;
  endtask

  task automatic test_simultaneous();
    int  t;
    ev_t e, o;
    bus.repeat_en = 2'b00;
    bus.btn_i = 2'b00;
    t = cyc;
    expect_ev(t + 10, "press",   2'b11);
    expect_ev(t + 25, "release", 2'b10);
    expect_ev(t + 42, "long",    2'b01);
    expect_ev(t + 55, "release", 2'b01);
    tick(15);
    checks++; if (bus.level_o !== 2'b11) $display("FAIL simul_level_both: got %b want 11", bus.level_o); else passed++;
    bus.btn_i[1] = 1'b1;
    tick(30);
    checks++; if (bus.level_o !== 2'b01) $display("FAIL simul_level_ch0: got %b want 01", bus.level_o); else passed++;
    bus.btn_i[0] = 1'b1;
    tick(15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL simul_event: missing %s@%0d=%b", e.kind, e.cyc, e.val);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind != e.kind || o.val !== e.val)
          $display("FAIL simul_event: got %s@%0d=%b want %s@%0d=%b", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        else passed++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL simul_extra: got %s@%0d=%b want none", obs_q[0].kind, obs_q[0].cyc, obs_q[0].val);
      obs_q.delete();
    end else passed++;
  endtask

  task automatic test_reset_mid_hold();
    int  p;
    ev_t e, o;
    bus.repeat_en = 2'b01;
    bus.btn_i[0] = 1'b0;
    p = cyc + 10;
    expect_ev(p,      "press",   2'b01);
    expect_ev(p + 32, "long",    2'b01);
    expect_ev(p + 32, "repeat",  2'b01);
    expect_ev(p + 40, "repeat",  2'b01);
    expect_ev(p + 53, "press",   2'b01);
    expect_ev(p + 66, "release", 2'b01);
    tick(52);
    reset = 1'b1;
    tick(1);
    checks++;
    if ({bus.level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o} !== 10'd0)
      $display("FAIL midreset_outputs: got %b want all zero",
               {bus.level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o});
    else passed++;
    reset = 1'b0;
    tick(13);
    bus.btn_i[0] = 1'b1;
    tick(14);
    bus.repeat_en = 2'b00;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL midreset_event: missing %s@%0d=%b", e.kind, e.cyc, e.val);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind != e.kind || o.val !== e.val)
          $display("FAIL midreset_event: got %s@%0d=%b want %s@%0d=%b", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        else passed++;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      $display("FAIL midreset_extra: got %s@%0d=%b want none", obs_q[0].kind, obs_q[0].cyc, obs_q[0].val);
      obs_q.delete();
    end else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset = 1'b1;
    bus.btn_i = 2'b11;
    bus.repeat_en = 2'b00;
    tick(3);
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_repeat_gating();
    test_simultaneous();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
